// File: rtl/mem_access_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// defines : shared types and constants for the mem_access data-memory stage
// Rev 1.0
// ---------------------------------------------------------------------------
package defines;

  typedef logic [31:0] data_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  // funct3[1:0] encodes access width; funct3[2] marks unsigned loads
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      SIZE_B:  return 1'b1;
      SIZE_H:  return ~addr_lo[0];
      default: return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_if : data-memory request/acknowledge bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_access_if;
  import defines::*;

  logic        mem_req;
  logic        mem_we;
  data_t       mem_addr;
  logic [3:0]  mem_be;
  data_t       mem_wdata;
  logic        mem_ack;
  data_t       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align : byte-enable / store-lane replication and load lane extension
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_align
  import defines::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  input  data_t      store_data_i,
  input  data_t      load_word_i,
  output logic [3:0] be_o,
  output data_t      wdata_o,
  output data_t      load_data_o
);

  data_t shifted;

  always_comb begin
    shifted     = load_word_i >> {addr_lo_i, 3'b000};
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = shifted;
    case (funct3_i[1:0])
      SIZE_B: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = funct3_i[2] ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = funct3_i[2] ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access : MEM pipeline stage, one outstanding data-memory transaction
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_access
  import defines::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  instr_t          instr,
  input  data_t           alu_result,
  input  data_t           rs2_fwd,
  input  logic            flush,
  mem_access_if.master    bus,
  output logic            stall,
  output logic            wb_valid,
  output data_t           wb_data,
  output logic            misalign
);

  mem_state_t state_q, state_d;
  data_t      addr_q, addr_d;
  logic [3:0] be_q, be_d;
  data_t      wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic       wb_valid_q, wb_valid_d;
  data_t      wb_data_q, wb_data_d;
  logic       misalign_q, misalign_d;

  logic       is_mem;
  logic       aligned;
  logic [2:0] al_funct3;
  logic [1:0] al_addr;
  logic [3:0] al_be;
  data_t      al_wdata;
  data_t      al_load;
  logic       unused_instr_bits;

  assign is_mem  = (instr.opcode == LOAD) || (instr.opcode == STORE);
  assign aligned = is_aligned(instr.funct3, alu_result[1:0]);
  assign unused_instr_bits = ^{instr.funct7, instr.rs2, instr.rs1, instr.rd};

  // One aligner serves both paths: incoming store in IDLE, returning load otherwise
  assign al_funct3 = (state_q == IDLE) ? instr.funct3     : f3_q;
  assign al_addr   = (state_q == IDLE) ? alu_result[1:0]  : off_q;

  mem_align u_align (
    .funct3_i     (al_funct3),
    .addr_lo_i    (al_addr),
    .store_data_i (rs2_fwd),
    .load_word_i  (bus.mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
          end else if (!aligned) begin
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
            wb_data_d  = alu_result;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = al_be;
            wdata_d = al_wdata;
            we_d    = (instr.opcode == STORE);
            f3_d    = instr.funct3;
            off_d   = alu_result[1:0];
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? '0 : al_load;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access : directed bench with a per-cycle transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_access;
  import defines::*;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  logic   clk = 1'b0;
  logic   rst, in_valid, flush;
  instr_t instr;
  data_t  alu_result, rs2_fwd;
  logic   stall, wb_valid, misalign;
  data_t  wb_data;

  mem_access_if bus ();

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .instr      (instr),
    .alu_result (alu_result),
    .rs2_fwd    (rs2_fwd),
    .flush      (flush),
    .bus        (bus),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules, plain arithmetic ----------------
  function automatic int f_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic f_aligned(input logic [2:0] f3, input logic [1:0] a);
    return (int'(a) % f_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    int sz, off;
    sz  = f_size(f3);
    off = (sz == 4) ? 0 : int'(a);
    be  = '0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) be[i] = 1'b1;
    return be;
  endfunction

  function automatic data_t f_wdata(input logic [2:0] f3, input data_t rs2);
    int sz;
    sz = f_size(f3);
    if (sz == 1) return (rs2 & 32'h0000_00FF) * 32'h0101_0101;
    if (sz == 2) return (rs2 & 32'h0000_FFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic data_t f_load(input logic [2:0] f3, input logic [1:0] off, input data_t word);
    longint v, lim;
    int sz;
    sz = f_size(f3);
    if (sz == 4) return word;
    lim = longint'(1) << (8 * sz);
    v   = longint'(word >> (8 * int'(off))) % lim;
    if (!f3[2] && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // ---------------- model state and per-cycle compare ----------------
  logic       m_started = 1'b0;
  logic       m_busy = 1'b0, m_resp = 1'b0, m_wbv = 1'b0, m_mis = 1'b0, m_we = 1'b0;
  data_t      m_wbd = '0, m_addr = '0, m_wdata = '0;
  logic [3:0] m_be = '0;
  logic [2:0] m_f3 = '0;
  logic [1:0] m_off = '0;
  logic       e_stall, is_memop;

  initial begin
    forever begin
      @(negedge clk);
      is_memop = (instr.opcode == LOAD) || (instr.opcode == STORE);
      if (m_started) begin
        e_stall = m_busy || (!m_resp && in_valid && !flush && is_memop &&
                             f_aligned(instr.funct3, alu_result[1:0]));
        chk("stall",    32'(stall),        32'(e_stall));
        chk("mem_req",  32'(bus.mem_req),  32'(m_busy));
        chk("wb_valid", 32'(wb_valid),     32'(m_wbv));
        chk("misalign", 32'(misalign),     32'(m_mis));
        if (m_busy) begin
          chk("mem_addr",  bus.mem_addr,       m_addr);
          chk("mem_be",    32'(bus.mem_be),    32'(m_be));
          chk("mem_wdata", bus.mem_wdata,      m_wdata);
          chk("mem_we",    32'(bus.mem_we),    32'(m_we));
        end
        if (m_wbv) chk("wb_data", wb_data, m_wbd);
      end
      // advance: inputs seen now are what the DUT samples at the next rising edge
      if (rst) begin
        m_started = 1'b1;
        m_busy = 1'b0; m_resp = 1'b0; m_wbv = 1'b0; m_mis = 1'b0; m_wbd = '0;
      end else if (m_started) begin
        m_wbv = 1'b0;
        m_mis = 1'b0;
        if (m_resp) begin
          m_resp = 1'b0;
        end else if (m_busy) begin
          if (bus.mem_ack) begin
            m_busy = 1'b0;
            m_resp = 1'b1;
            m_wbv  = 1'b1;
            m_wbd  = m_we ? 32'h0 : f_load(m_f3, m_off, bus.mem_rdata);
          end
        end else if (in_valid && !flush) begin
          if (!is_memop) begin
            m_wbv = 1'b1;
            m_wbd = alu_result;
          end else if (!f_aligned(instr.funct3, alu_result[1:0])) begin
            m_wbv = 1'b1;
            m_mis = 1'b1;
            m_wbd = alu_result;
          end else begin
            m_busy  = 1'b1;
            m_addr  = alu_result & 32'hFFFF_FFFC;
            m_be    = f_be(instr.funct3, alu_result[1:0]);
            m_wdata = f_wdata(instr.funct3, rs2_fwd);
            m_we    = (instr.opcode == STORE);
            m_f3    = instr.funct3;
            m_off   = alu_result[1:0];
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int         o_stall, o_wbv, o_wbv_at;
  logic       o_req, o_mis, o_we;
  data_t      o_addr, o_wdata, o_wbd;
  logic [3:0] o_be;

  // called at rising edge + 2; holds the instruction while stall is high
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input data_t alu,
                        input data_t rs2, input logic fl, input int ack_delay, input data_t rdata);
    int   req_cnt;
    logic held;
    req_cnt = 0;
    o_stall = 0; o_wbv = 0; o_wbv_at = -1; o_req = 1'b0; o_mis = 1'b0; o_we = 1'b0;
    o_addr = '0; o_wdata = '0; o_wbd = '0; o_be = '0;
    instr = '0; instr.opcode = op; instr.funct3 = f3;
    alu_result = alu; rs2_fwd = rs2; flush = fl; in_valid = 1'b1;
    for (int c = 0; c < ack_delay + 5; c++) begin
      if (bus.mem_req) req_cnt++;
      bus.mem_ack   = bus.mem_req && (req_cnt == ack_delay);
      bus.mem_rdata = bus.mem_ack ? rdata : 32'h0;
      @(negedge clk);
      if (stall) o_stall++;
      if (wb_valid) begin
        if (o_wbv == 0) o_wbv_at = c;
        o_wbv++;
        o_wbd = wb_data;
        o_mis = misalign;
      end
      if (bus.mem_req && !o_req) begin
        o_req = 1'b1; o_addr = bus.mem_addr; o_be = bus.mem_be;
        o_wdata = bus.mem_wdata; o_we = bus.mem_we;
      end
      held = stall;
      @(posedge clk); #2;
      if (!held) begin in_valid = 1'b0; flush = 1'b0; end
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; instr = '0;
    alu_result = '0; rs2_fwd = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst mem_addr",  bus.mem_addr,      32'h0);
    chk("rst mem_wdata", bus.mem_wdata,     32'h0);
    chk("rst mem_be",    32'(bus.mem_be),   32'h0);
    chk("rst wb_data",   wb_data,           32'h0);
    chk("rst mem_we",    32'(bus.mem_we),   32'h0);
    @(posedge clk); #2;

    // SW, ack on the third request cycle
    run_op(STORE, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 3, 32'h0);
    chk("sw addr",    o_addr,       32'h0000_0104);
    chk("sw be",      32'(o_be),    32'h0000_000F);
    chk("sw wdata",   o_wdata,      32'hDEAD_BEEF);
    chk("sw we",      32'(o_we),    32'h1);
    chk("sw stall",   32'(o_stall), 32'd4);
    chk("sw wbv cnt", 32'(o_wbv),   32'd1);
    chk("sw wb_data", o_wbd,        32'h0);

    // SB to the top lane
    run_op(STORE, 3'b000, 32'h0000_0203, 32'h0000_00A5, 1'b0, 2, 32'h0);
    chk("sb addr",  o_addr,    32'h0000_0200);
    chk("sb be",    32'(o_be), 32'h0000_0008);
    chk("sb wdata", o_wdata,   32'hA5A5_A5A5);

    // LB / LBU on the same word
    run_op(LOAD, 3'b000, 32'h0000_0101, 32'h0, 1'b0, 1, 32'h0000_8000);
    chk("lb wb_data",  o_wbd,          32'hFFFF_FF80);
    chk("lb be",       32'(o_be),      32'h0000_0002);
    chk("lb latency",  32'(o_wbv_at),  32'd2);
    run_op(LOAD, 3'b100, 32'h0000_0101, 32'h0, 1'b0, 2, 32'h0000_8000);
    chk("lbu wb_data", o_wbd,          32'h0000_0080);
    chk("lbu latency", 32'(o_wbv_at),  32'd3);

    // LH / LHU at offset 2, LW at offset 2 is misaligned
    run_op(LOAD, 3'b001, 32'h0000_0102, 32'h0, 1'b0, 1, 32'h8001_0000);
    chk("lh misalign", 32'(o_mis), 32'h0);
    chk("lh be",       32'(o_be),  32'h0000_000C);
    chk("lh wb_data",  o_wbd,      32'hFFFF_8001);
    run_op(LOAD, 3'b101, 32'h0000_0102, 32'h0, 1'b0, 1, 32'h8001_0000);
    chk("lhu wb_data", o_wbd,      32'h0000_8001);
    run_op(LOAD, 3'b010, 32'h0000_0102, 32'h0, 1'b0, 0, 32'h0);
    chk("lw mis flag",  32'(o_mis),   32'h1);
    chk("lw mis req",   32'(o_req),   32'h0);
    chk("lw mis data",  o_wbd,        32'h0000_0102);
    chk("lw mis stall", 32'(o_stall), 32'h0);

    // ALU pass-through
    run_op(OPC_OP, 3'b000, 32'h0000_0055, 32'h0, 1'b0, 0, 32'h0);
    chk("add wbv at",  32'(o_wbv_at), 32'd1);
    chk("add wb_data", o_wbd,         32'h0000_0055);
    chk("add stall",   32'(o_stall),  32'h0);

    // flushed load in IDLE
    run_op(LOAD, 3'b010, 32'h0000_0300, 32'h0, 1'b1, 0, 32'h0);
    chk("flush req", 32'(o_req), 32'h0);
    chk("flush wbv", 32'(o_wbv), 32'h0);

    // reset while a load is in REQ, then a stray acknowledge
    instr = '0; instr.opcode = LOAD; instr.funct3 = 3'b010;
    alu_result = 32'h0000_0400; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    @(negedge clk);
    chk("pre-rst req", 32'(bus.mem_req), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("post-rst req",   32'(bus.mem_req), 32'h0);
    chk("post-rst stall", 32'(stall),       32'h0);
    @(posedge clk); #2;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray ack wbv", 32'(wb_valid), 32'h0);
    @(posedge clk); #2;

    run_op(OPC_OP, 3'b000, 32'h0000_0077, 32'h0, 1'b0, 0, 32'h0);
    chk("after rst add", o_wbd, 32'h0000_0077);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Ports SHALL be, clock and reset first (name direction width meaning):
clk  in  1  single clock, all state on rising edge;
rst  in  1  synchronous, active-high reset;
in_valid  in  1  EX/MEM register holds a live instruction;
instr  in  instr_t  instruction (opcode, funct3 used);
alu_result  in  data_t  effective address, or pass-through result;
rs2_fwd  in  data_t  forwarded store data;
flush  in  1  squash the accepted-but-unissued instruction;
mem_req  out  1  data-memory request;
mem_we  out  1  write enable;
mem_addr  out  data_t  word-aligned address, bits[1:0]=0;
mem_be  out  4  byte enables;
mem_wdata  out  data_t  lane-shifted store data;
mem_ack  in  1  one-cycle completion pulse;
mem_rdata  in  data_t  read word, valid with mem_ack;
stall  out  1  freeze upstream stages;
wb_valid  out  1  wb_data/misalign valid, one-cycle pulse;
wb_data  out  data_t  load result or passed alu_result;
misalign  out  1  access not aligned to its size.

Function
REQ-002 FSM states SHALL be IDLE, REQ, RESP.
REQ-003 In IDLE, in_valid with a non-memory opcode and flush=0 SHALL produce wb_valid=1 and wb_data=alu_result on the next cycle; the FSM stays in IDLE.
REQ-004 In IDLE, in_valid with a LOAD/STORE opcode, aligned and flush=0, SHALL register address, be, wdata and we, then enter REQ; mem_req SHALL rise on the next cycle.
REQ-005 Alignment: a halfword SHALL need addr[0]=0 and a word SHALL need addr[1:0]=0; a byte is always aligned.
REQ-006 A misaligned access SHALL issue no request; on the next cycle wb_valid=1, misalign=1 and wb_data=alu_result; no store side effect.
REQ-007 mem_be SHALL be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111. Loads SHALL use the same pattern for their width.
REQ-008 mem_wdata SHALL replicate the store byte or halfword across all lanes; SW SHALL pass rs2_fwd unchanged.
REQ-009 In REQ, mem_req and all mem_* outputs SHALL stay stable until the cycle mem_ack=1; that cycle the FSM SHALL enter RESP and register mem_rdata.
REQ-010 In RESP, the FSM SHALL pulse wb_valid for one cycle and return to IDLE; wb_data SHALL be:
- LB/LH: the selected lane, sign-extended;
- LBU/LHU: the selected lane, zero-extended;
- LW: the word;
- stores: 0.
REQ-011 stall SHALL be high in REQ, and combinationally high in IDLE when an aligned memory op is accepted; stall SHALL be low in RESP, so upstream advances on the RESP cycle.
REQ-012 flush in IDLE SHALL discard the instruction: no request and no wb_valid. flush in REQ or RESP SHALL be ignored, because a bus transaction cannot be cancelled.
REQ-013 mem_ack outside REQ SHALL be ignored.
REQ-014 Total load latency SHALL be 2 cycles plus the memory wait cycles: accept, then at least one REQ cycle, then RESP.

Reset
REQ-015 On rst=1 at a clock edge, the FSM SHALL go to IDLE, and mem_req, mem_we, mem_be, wb_valid, misalign and stall-state SHALL be cleared; mem_addr, mem_wdata and wb_data SHALL reset to 0.
REQ-016 Reset during REQ SHALL abandon the transaction; a later mem_ack SHALL be ignored per REQ-013.

Structure
REQ-017 The mem_state_t enum, the opcode constants LOAD/STORE and the funct3 width constants SHALL live in package defines, alongside data_t and instr_t.
REQ-018 Lane shifting and load extension SHALL be one combinational sub-module, mem_align, used for both the store and the load paths.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- SW addr 0x104, rs2 0xDEADBEEF, ack after 3 cycles -> mem_addr 0x104, be 1111, wdata 0xDEADBEEF, stall high 4 cycles, one wb_valid.
- SB addr 0x203, rs2 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
- LB addr 0x101, rdata 0x0000_80_00 -> wb_data 0xFFFFFF80; LBU on the same word -> 0x00000080.
- LH addr 0x102 -> misalign=0, be 1100; LW addr 0x102 -> misalign=1, mem_req never asserts, wb_data 0x102.
- ADD result 0x55 -> wb_valid next cycle, wb_data 0x55, stall never high.
- Two events, each checked separately:
  - flush with a load in IDLE -> no mem_req, no wb_valid.
  - rst asserted in REQ, then a spurious mem_ack -> FSM in IDLE, no wb_valid.
